result_seg_display: RTL

RESULT_SEG_DISPLAY -- requirements
Module: result_seg_display

---
 rtl/result_seg_display.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/result_seg_display.sv
//==============================================================================
// Module   : result_seg_display
// Purpose  : Double-dabble binary-to-BCD conversion of a 16-bit result and a
//            multiplexed 4-digit active-low 7-segment display driver.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module result_seg_display #(
    parameter int CLK_HZ   = 50000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        conv_done,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  dig_sel
);

    localparam int c_DIV_RAW = CLK_HZ / SCAN_HZ;
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_PW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            w_capture;
    logic            w_shift;
    logic            w_done;

    logic [15:0]     r_sreg;
    logic [15:0]     r_bcd;
    logic [3:0]      r_n5;
    logic [3:0]      r_cnt_sh;
    logic [15:0]     w_bcd_adj;

    logic [15:0]     r_disp;
    logic            r_ovf;
    logic            r_conv_done;

    logic [c_PW-1:0] r_pre;
    logic            w_tick;
    logic [1:0]      r_idx;
    logic [3:0]      w_blank;
    logic [3:0]      w_nib;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:  if (load) w_next = c_S_SHIFT;
            c_S_SHIFT: if (r_cnt_sh == 4'd15) w_next = c_S_DONE;
            c_S_DONE:  w_next = c_S_IDLE;
            default:   w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        w_capture = 1'b0;
        w_shift   = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            c_S_IDLE:  w_capture = load;
            c_S_SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
            end
            c_S_DONE:  begin
                busy   = 1'b1;
                w_done = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

    // ---------------- Double-dabble datapath ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_add3
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg      <= '0;
            r_bcd       <= '0;
            r_n5        <= '0;
            r_cnt_sh    <= '0;
            r_disp      <= '0;
            r_ovf       <= 1'b0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            if (w_capture) begin
                r_sreg   <= value;
                r_bcd    <= '0;
                r_n5     <= '0;
                r_cnt_sh <= '0;
            end else if (w_shift) begin
                r_n5     <= {r_n5[2:0], w_bcd_adj[15]};
                r_bcd    <= {w_bcd_adj[14:0], r_sreg[15]};
                r_sreg   <= {r_sreg[14:0], 1'b0};
                r_cnt_sh <= r_cnt_sh + 4'd1;
            end else if (w_done) begin
                r_disp      <= r_bcd;
                r_ovf       <= (r_n5 != 4'd0);
                r_conv_done <= 1'b1;
            end
        end
    end

    assign conv_done = r_conv_done;
    assign ovf       = r_ovf;

    // ---------------- Scan prescaler and digit index ----------------
    assign w_tick = (r_pre == c_PW'(c_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // A digit blanks only when it and every more-significant digit are zero.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_blank
            if (gi == 0) begin : g_units
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = (BLANK_LZ != 0) && !r_ovf &&
                                     (r_disp[15:4*gi] == '0);
            end
        end
    endgenerate

    assign w_nib   = r_disp[4*r_idx +: 4];
    assign dig_sel = ~(4'b0001 << r_idx);

    always_comb begin
        seg = 7'h7F;
        if (!w_blank[r_idx]) begin
            case (w_nib)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule

`default_nettype wire
